// File: rtl/lfsr_defs.sv
// Shared definitions for the PRBS generator/checker: checker FSM encodings
// and the default polynomial/seed constants.
package lfsr_defs;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } chk_state_e;

    // x^8 + x^4 + x^3 + x^2 + 1 in Galois tap-mask form
    localparam logic [7:0] DEF_POLY = 8'h1D;
    localparam logic [7:0] DEF_SEED = 8'h01;

    // Wide enough for a lock/unlock run length of up to 15
    localparam int RUN_BITS = 4;

endpackage

// File: rtl/lfsr_step.sv
// One Galois LFSR step: shift left, fold the tap mask in when the MSB drops out.
module lfsr_step #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] POLY  = WIDTH'(8'h1D)
) (
    input  logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] nxt
);

    assign nxt = {s[WIDTH-2:0], 1'b0} ^ (s[WIDTH-1] ? POLY : '0);

endmodule

// File: rtl/lfsr_prbs_gen_chk.sv
// PRBS generator plus self-synchronising checker with lock detection and a
// saturating error counter. Generator and checker share only the step function.
module lfsr_prbs_gen_chk
    import lfsr_defs::*;
#(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] POLY     = WIDTH'(DEF_POLY),
    parameter logic [WIDTH-1:0] SEED     = WIDTH'(DEF_SEED),
    parameter int               LOCK_CNT = 4,
    parameter int               CNT_W    = 16
) (
    input  logic             clk,
    input  logic             i_rst,
    input  logic             i_soft_reset,
    input  logic [WIDTH-1:0] i_seed,
    input  logic             i_valid,
    output logic [WIDTH-1:0] o_lfsr,
    input  logic             i_chk_valid,
    input  logic [WIDTH-1:0] i_chk_data,
    input  logic             i_err_clr,
    output logic             o_locked,
    output logic             o_err,
    output logic [CNT_W-1:0] o_err_cnt
);

    localparam logic [RUN_BITS-1:0] LOCK_RUN = RUN_BITS'(LOCK_CNT);

    // ------------------------------------------------------------ generator
    logic [WIDTH-1:0] gen_next;

    lfsr_step #(.WIDTH(WIDTH), .POLY(POLY)) u_gen_step (
        .s   (o_lfsr),
        .nxt (gen_next)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values, regardless of block ordering.
    always_ff @(posedge clk) begin
        if (i_rst)
            o_lfsr <= SEED;
        else if (i_soft_reset)
            o_lfsr <= (i_seed == '0) ? SEED : i_seed;
        else if (i_valid)
            o_lfsr <= gen_next;
    end

    // -------------------------------------------------------------- checker
    chk_state_e          state_q, state_d;
    logic [WIDTH-1:0]    exp_q, exp_d;
    logic [RUN_BITS-1:0] run_q, run_d;
    logic [RUN_BITS-1:0] run_inc;
    logic                err_d;
    logic [CNT_W-1:0]    err_cnt_d;
    logic [WIDTH-1:0]    data_next, exp_next;
    logic                match, data_nz;

    lfsr_step #(.WIDTH(WIDTH), .POLY(POLY)) u_data_step (
        .s   (i_chk_data),
        .nxt (data_next)
    );

    lfsr_step #(.WIDTH(WIDTH), .POLY(POLY)) u_exp_step (
        .s   (exp_q),
        .nxt (exp_next)
    );

    assign match   = (i_chk_data == exp_q);
    assign data_nz = (i_chk_data != '0);
    assign run_inc = run_q + 1'b1;

    // NOTE: every output of this block gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d   = state_q;
        exp_d     = exp_q;
        run_d     = run_q;
        err_d     = 1'b0;
        err_cnt_d = o_err_cnt;

        if (i_chk_valid) begin
            case (state_q)
                ST_SEARCH: begin
                    if (data_nz) begin
                        exp_d   = data_next;
                        run_d   = '0;
                        state_d = ST_VERIFY;
                    end
                end
                ST_VERIFY: begin
                    if (match) begin
                        exp_d = exp_next;
                        if (run_inc == LOCK_RUN) begin
                            run_d   = '0;
                            state_d = ST_LOCKED;
                        end else begin
                            run_d = run_inc;
                        end
                    end else if (data_nz) begin
                        // Resynchronise on the new word rather than restart the search
                        exp_d = data_next;
                        run_d = '0;
                    end else begin
                        run_d   = '0;
                        state_d = ST_SEARCH;
                    end
                end
                ST_LOCKED: begin
                    exp_d = exp_next;
                    if (match) begin
                        run_d = '0;
                    end else begin
                        err_d = 1'b1;
                        if (o_err_cnt != '1)
                            err_cnt_d = o_err_cnt + 1'b1;
                        if (run_inc == LOCK_RUN) begin
                            run_d   = '0;
                            state_d = ST_SEARCH;
                        end else begin
                            run_d = run_inc;
                        end
                    end
                end
                default: begin
                    run_d   = '0;
                    state_d = ST_SEARCH;
                end
            endcase
        end

        if (i_err_clr)
            err_cnt_d = '0;
    end

    // NOTE: the reset here is synchronous; it is a plain priority branch
    // sampled on the clock edge, not part of the sensitivity list.
    always_ff @(posedge clk) begin
        if (i_rst) begin
            state_q   <= ST_SEARCH;
            exp_q     <= '0;
            run_q     <= '0;
            o_locked  <= 1'b0;
            o_err     <= 1'b0;
            o_err_cnt <= '0;
        end else begin
            state_q   <= state_d;
            exp_q     <= exp_d;
            run_q     <= run_d;
            o_locked  <= (state_d == ST_LOCKED);
            o_err     <= err_d;
            o_err_cnt <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_lfsr_prbs_gen_chk.sv
// Directed bench for lfsr_prbs_gen_chk: generator sequence, seeding, lock,
// error counting, unlock/relock and reset behaviour with default parameters.
module tb_lfsr_prbs_gen_chk;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_soft_reset;
    logic [7:0]  i_seed;
    logic        i_valid;
    logic [7:0]  o_lfsr;
    logic        i_chk_valid;
    logic [7:0]  i_chk_data;
    logic        i_err_clr;
    logic        o_locked;
    logic        o_err;
    logic [15:0] o_err_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    lfsr_prbs_gen_chk dut (
        .clk          (clk),
        .i_rst        (i_rst),
        .i_soft_reset (i_soft_reset),
        .i_seed       (i_seed),
        .i_valid      (i_valid),
        .o_lfsr       (o_lfsr),
        .i_chk_valid  (i_chk_valid),
        .i_chk_data   (i_chk_data),
        .i_err_clr    (i_err_clr),
        .o_locked     (o_locked),
        .o_err        (o_err),
        .o_err_cnt    (o_err_cnt)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Feed the generator output straight back into the checker for one word.
    task automatic loop_word(input logic corrupt, input logic clr);
        i_valid     = 1'b1;
        i_chk_valid = 1'b1;
        i_chk_data  = o_lfsr ^ {7'd0, corrupt};
        i_err_clr   = clr;
        tick();
        i_err_clr   = 1'b0;
    endtask

    task automatic words_to_lock(output int n);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            loop_word(1'b0, 1'b0);
            n++;
            if (o_locked) break;
        end
    endtask

    logic [7:0] seq_exp [8] = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1D};

    initial begin
        int n;
        logic zero_seen;
        logic early_return;

        i_rst = 1'b1; i_soft_reset = 1'b0; i_seed = '0; i_valid = 1'b0;
        i_chk_valid = 1'b0; i_chk_data = '0; i_err_clr = 1'b0;
        tick(); tick();
        check("rst_lfsr",    o_lfsr,    8'h01);
        check("rst_locked",  o_locked,  1'b0);
        check("rst_err",     o_err,     1'b0);
        check("rst_err_cnt", o_err_cnt, 16'd0);
        i_rst = 1'b0;

        // First eight steps of x^8+x^4+x^3+x^2+1 from seed 01
        i_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("seq_%0d", i), o_lfsr, seq_exp[i]);
        end

        // Remaining 247 steps close the 255-state cycle
        zero_seen = 1'b0;
        early_return = 1'b0;
        for (int i = 0; i < 247; i++) begin
            tick();
            if (o_lfsr == 8'h00) zero_seen = 1'b1;
            if (o_lfsr == 8'h01 && i != 246) early_return = 1'b1;
        end
        check("period_end",   o_lfsr,       8'h01);
        check("no_zero",      zero_seen,    1'b0);
        check("no_short_cyc", early_return, 1'b0);

        i_valid = 1'b0;
        tick();
        check("hold", o_lfsr, 8'h01);

        // Seeding: zero seed falls back to SEED, soft reset beats i_valid
        i_valid = 1'b1;
        tick(); tick(); tick();
        check("pre_seed", o_lfsr, 8'h08);
        i_valid = 1'b0; i_soft_reset = 1'b1; i_seed = 8'h00;
        tick();
        check("seed_zero", o_lfsr, 8'h01);
        i_seed = 8'hA5;
        tick();
        check("seed_a5", o_lfsr, 8'hA5);
        i_seed = 8'h33; i_valid = 1'b1;
        tick();
        check("seed_over_valid", o_lfsr, 8'h33);
        i_rst = 1'b1; i_seed = 8'hA5;
        tick();
        check("rst_over_soft", o_lfsr, 8'h01);
        i_rst = 1'b0; i_soft_reset = 1'b0; i_valid = 1'b0;

        // Loopback lock: one word to seed, LOCK_CNT matches to confirm
        words_to_lock(n);
        check("lock_words",   n,         5);
        check("lock_state",   o_locked,  1'b1);
        check("lock_err_cnt", o_err_cnt, 16'd0);

        // Single corrupt word while locked
        loop_word(1'b1, 1'b0);
        check("single_err",     o_err,     1'b1);
        check("single_cnt",     o_err_cnt, 16'd1);
        check("single_locked",  o_locked,  1'b1);
        loop_word(1'b0, 1'b0);
        check("single_err_end", o_err,     1'b0);
        check("single_hold",    o_locked,  1'b1);

        // Clear on a clean word, then four corrupt words to unlock
        loop_word(1'b0, 1'b1);
        check("clr_cnt", o_err_cnt, 16'd0);
        for (int i = 0; i < 3; i++) loop_word(1'b1, 1'b0);
        check("burst3_locked", o_locked,  1'b1);
        check("burst3_cnt",    o_err_cnt, 16'd3);
        loop_word(1'b1, 1'b0);
        check("burst4_locked", o_locked,  1'b0);
        check("burst4_cnt",    o_err_cnt, 16'd4);
        check("burst4_err",    o_err,     1'b1);

        // Errors are not counted while out of lock
        words_to_lock(n);
        check("relock_words", n,         5);
        check("relock_cnt",   o_err_cnt, 16'd4);

        // Clear coincident with an error wins; the pulse still fires
        loop_word(1'b1, 1'b1);
        check("clr_vs_err_cnt", o_err_cnt, 16'd0);
        check("clr_vs_err_err", o_err,     1'b1);

        // Soft reset of the generator leaves the checker untouched
        i_chk_valid = 1'b0; i_valid = 1'b0; i_soft_reset = 1'b1; i_seed = 8'h5A;
        tick();
        i_soft_reset = 1'b0;
        check("soft_gen",    o_lfsr,   8'h5A);
        check("soft_locked", o_locked, 1'b1);

        // Reset mid-lock with a corrupt word present
        i_rst = 1'b1; i_chk_valid = 1'b1; i_chk_data = 8'h00; i_valid = 1'b1;
        tick();
        check("midrst_locked", o_locked,  1'b0);
        check("midrst_err",    o_err,     1'b0);
        check("midrst_cnt",    o_err_cnt, 16'd0);
        check("midrst_lfsr",   o_lfsr,    8'h01);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lfsr_prbs_gen_chk.md
LFSR_PRBS_GEN_CHK -- requirements
Module: lfsr_prbs_gen_chk

Interface
REQ-001 Parameter WIDTH, default 8: LFSR state and data width; legal range 3..32.
REQ-002 Parameter POLY, default 8'h1D: Galois tap mask, bit k set means feedback XORs into bit k. Default gives x^8+x^4+x^3+x^2+1.
REQ-003 Parameter SEED, default 1: fixed non-zero reset seed.
REQ-004 Parameter LOCK_CNT, default 4: consecutive matches to lock, and consecutive misses to unlock; range 1..15.
REQ-005 Parameter CNT_W, default 16: error counter width.
REQ-006 Ports (name, direction, width, meaning):
- clk  in  1  system clock; single clock domain.
- i_rst  in  1  reset, synchronous, active-high.
- i_soft_reset  in  1  load generator with i_seed.
- i_seed  in  WIDTH  runtime seed.
- i_valid  in  1  advance generator one step.
- o_lfsr  out  WIDTH  generator state (registered).
- i_chk_valid  in  1  i_chk_data qualifier.
- i_chk_data  in  WIDTH  received PRBS word.
- i_err_clr  in  1  clear error counter.
- o_locked  out  1  checker locked.
- o_err  out  1  one-cycle mismatch pulse.
- o_err_cnt  out  CNT_W  saturating error count.

Function
REQ-007 The step function SHALL be next = (s << 1) truncated to WIDTH, XOR POLY when s[WIDTH-1] = 1.
REQ-008 Generator priority SHALL be i_rst > i_soft_reset > i_valid > hold. o_lfsr updates one cycle after the qualifying edge.
REQ-009 On i_soft_reset with i_seed = 0, the generator SHALL load SEED instead (lock-up avoidance). Any non-zero i_seed loads as given.
REQ-010 The generator SHALL never hold the all-zero state.
REQ-011 The checker SHALL hold an expected-word register exp and use FSM states SEARCH, VERIFY, LOCKED. Only cycles with i_chk_valid = 1 change checker state.
REQ-012 SEARCH: a non-zero word SHALL set exp <= step(word) and cnt <= 0, then move to VERIFY. A zero word SHALL keep the checker in SEARCH.
REQ-013 VERIFY, word == exp: exp <= step(exp), cnt increments. When the count reaches LOCK_CNT, the FSM SHALL go to LOCKED with cnt <= 0.
REQ-014 VERIFY, word != exp: a non-zero word SHALL reseed (exp <= step(word), cnt <= 0) and stay in VERIFY. A zero word SHALL go to SEARCH.
REQ-015 LOCKED: exp <= step(exp) SHALL run every valid word.
- Match: cnt <= 0.
- Mismatch: o_err pulses the next cycle, o_err_cnt increments (saturating at all-ones), cnt increments.
- LOCK_CNT consecutive mismatches: go to SEARCH; o_locked falls the same cycle.
REQ-016 o_locked SHALL be registered, asserted exactly while the FSM is in LOCKED.
REQ-017 Errors SHALL be counted only in LOCKED.
REQ-018 i_err_clr SHALL zero o_err_cnt next cycle and takes priority over a simultaneous increment (result 0). o_err still pulses.
REQ-019 Generator and checker SHALL be independent; i_soft_reset does not affect the checker.

Reset
REQ-020 On i_rst high at a clk edge the block SHALL load:
- o_lfsr = SEED
- checker in SEARCH, exp = 0, cnt = 0
- o_locked = 0, o_err = 0, o_err_cnt = 0
REQ-021 i_rst asserted mid-lock SHALL drop o_locked the next cycle; all other inputs are ignored that cycle.

Structure
REQ-022 A shared header lfsr_defs SHALL hold the FSM state encodings (2-bit) and default POLY/SEED constants.
REQ-023 The combinational next-state logic SHALL be a sub-module lfsr_step (WIDTH, POLY), instantiated for the generator and the checker.

Verification
REQ-024 Sequence: reset, then 8 i_valid pulses -> o_lfsr = 01,02,04,08,10,20,40,80,1D; 255 steps return to 01 with no 00 seen.
REQ-025 Zero seed: i_soft_reset with i_seed = 00 -> o_lfsr = 01. With i_seed = A5 -> o_lfsr = A5. Simultaneous i_rst and i_soft_reset -> 01.
REQ-026 Lock: loopback o_lfsr to i_chk_data with valid every cycle -> o_locked rises after exactly 1 + LOCK_CNT = 5 valid words; o_err_cnt stays 0.
REQ-027 Single error: while locked, flip bit 0 of one word -> one o_err pulse, o_err_cnt = 1, o_locked stays 1.
REQ-028 Four consecutive corrupt words -> o_err_cnt = 4, o_locked = 0. Clean stream resumes -> relock after 5 words. i_err_clr coincident with an error -> o_err_cnt = 0.
